sub_32_seq: RTL

- Multi-cycle 32-bit subtractor: diff = a - b - bin, with borrow-out and signed overflow.
- It is the inverse-direction companion to the team's 32-bit ripple full adder. It is used wherever subtraction is needed without a full 32-bit combinational borrow chain.
- Processes DIGIT bits per clock, least significant digit first.
- Uses a start/busy/done handshake, so an upstream controller can issue one operation at a time.

---
 rtl/sub_32_pkg.sv | 21 ++
 rtl/sub_32_seq_sub_digit.sv | 28 ++
 rtl/sub_32_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sub_32_pkg.sv
// Shared state encoding, default geometry and sizing helper for the
// digit-serial subtractor.
package sub_32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must reach N itself without wrapping, hence the extra bit.
  function automatic int step_width(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int WIDTH_DEF  = 32;
  localparam int DIGIT_DEF  = 4;
  localparam int N_DEF      = WIDTH_DEF / DIGIT_DEF;
  localparam int STEP_W_DEF = step_width(N_DEF);

endpackage

// File: rtl/sub_32_seq_sub_digit.sv
// Combinational DIGIT-bit borrow subtractor: x - y - bi, formed as a ripple
// of full-adder cells adding x + ~y + ~bi; the borrow is the inverted carry.
module sub_digit
  import sub_32_pkg::*;
#(
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] y_n;

  assign y_n  = ~y;
  assign c[0] = ~bi;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
    assign d[gi]   = x[gi] ^ y_n[gi] ^ c[gi];
    assign c[gi+1] = (x[gi] & y_n[gi]) | (c[gi] & (x[gi] ^ y_n[gi]));
  end

  assign bo = ~c[DIGIT];

endmodule

// File: rtl/sub_32_seq.sv
// Multi-cycle subtractor: diff = a - b - bin, resolved DIGIT bits per cycle,
// least significant digit first, behind a start/busy/done handshake.
module sub_32_seq
  import sub_32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N      = WIDTH / DIGIT;
  localparam int STEP_W = step_width(N);
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              borrow_q, borrow_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bout_q, bout_d;
  logic              ovf_q, ovf_d;

  logic [DIGIT-1:0]  a_dig [N];
  logic [DIGIT-1:0]  b_dig [N];
  logic [IDX_W-1:0]  idx;
  logic [DIGIT-1:0]  cur_a, cur_b, dig_d;
  logic              dig_bo;
  logic              last_step;

  // Split the latched operands into digits so the single slice adder can be
  // fed by a plain mux on the step counter.
  for (genvar gi = 0; gi < N; gi++) begin : g_split
    assign a_dig[gi] = a_q[gi*DIGIT +: DIGIT];
    assign b_dig[gi] = b_q[gi*DIGIT +: DIGIT];
  end

  assign idx       = step_q[IDX_W-1:0];
  assign cur_a     = a_dig[idx];
  assign cur_b     = b_dig[idx];
  assign last_step = (step_q == STEP_W'(N - 1));

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .x  (cur_a),
    .y  (cur_b),
    .bi (borrow_q),
    .d  (dig_d),
    .bo (dig_bo)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    step_d   = step_q;
    borrow_d = borrow_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          diff_d   = '0;
          step_d   = '0;
        end
      end
      RUN: begin
        for (int k = 0; k < N; k++) begin
          if (idx == IDX_W'(k)) diff_d[k*DIGIT +: DIGIT] = dig_d;
        end
        borrow_d = dig_bo;
        step_d   = step_q + STEP_W'(1);
        busy_d   = 1'b1;
        if (last_step) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bout_d  = dig_bo;
          // Top digit of the result is being produced right now.
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (dig_d[DIGIT-1] ^ a_q[WIDTH-1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      step_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      step_q   <= step_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule
